// File: rtl/booth_pkg.sv
// booth_pkg: shared defaults, FSM state encoding and the partial-product alignment helper.
package booth_pkg;
  localparam int BOOTH_N = 64;
  localparam int BOOTH_NPP = BOOTH_N / 2;
  localparam int BOOTH_KW = $clog2(BOOTH_NPP);
  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;
  function automatic logic [2*BOOTH_N-1:0] sext_shift(input logic [BOOTH_N:0] pp, input logic [BOOTH_KW-1:0] k);
    return {{(BOOTH_N-1){pp[BOOTH_N]}}, pp} << {k, 1'b0};
  endfunction
endpackage

// File: rtl/booth_pp_align.sv
// booth_pp_align: sign-extends a Booth partial product to 2N bits and aligns it by 2k.
module booth_pp_align #(
  parameter int N = 64,
  parameter int KW = 5
) (
  input  logic [N:0]     pp,
  input  logic [KW-1:0]  k,
  output logic [2*N-1:0] term
);
  assign term = {{(N-1){pp[N]}}, pp} << {k, 1'b0};
endmodule

// File: rtl/booth_pp_accumulator.sv
// booth_pp_accumulator: sequential Booth partial-product accumulator with valid/ready product output.
// BOOTH_CSA_ACC_EN selects a carry-save accumulator plus a final RESOLVE add.
module booth_pp_accumulator
  import booth_pkg::*;
#(
  parameter int N = BOOTH_N,
  parameter int NPP = N / 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           pp_valid,
  output logic           pp_ready,
  input  logic [N:0]     pp_data,
  output logic           busy,
  output logic           prod_valid,
  input  logic           prod_ready,
  output logic [2*N-1:0] prod
);
  localparam int KW = $clog2(NPP);
  state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [2*N-1:0] prod_q, prod_d, term;
  logic last;
`ifdef BOOTH_CSA_ACC_EN
  logic [2*N-1:0] sum_q, sum_d, carry_q, carry_d;
`else
  logic [2*N-1:0] acc_q, acc_d;
`endif
  booth_pp_align #(.N(N), .KW(KW)) u_align (.pp(pp_data), .k(k_q), .term(term));
  assign last = k_q == KW'(NPP - 1);
  assign pp_ready = state_q == ACCUM;
  assign busy = state_q != IDLE;
  assign prod_valid = state_q == DONE;
  assign prod = prod_q;
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    prod_d = prod_q;
`ifdef BOOTH_CSA_ACC_EN
    sum_d = sum_q;
    carry_d = carry_q;
`else
    acc_d = acc_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d = ACCUM;
        k_d = '0;
`ifdef BOOTH_CSA_ACC_EN
        sum_d = '0;
        carry_d = '0;
`else
        acc_d = '0;
`endif
      end
      ACCUM: if (pp_valid) begin
        k_d = last ? '0 : k_q + 1'b1;
`ifdef BOOTH_CSA_ACC_EN
        // 3:2 compression keeps the per-pp path free of carry propagation
        sum_d = sum_q ^ carry_q ^ term;
        carry_d = ((sum_q & carry_q) | (sum_q & term) | (carry_q & term)) << 1;
        state_d = last ? RESOLVE : ACCUM;
`else
        acc_d = acc_q + term;
        state_d = last ? DONE : ACCUM;
        prod_d = last ? acc_d : prod_q;
`endif
      end
`ifdef BOOTH_CSA_ACC_EN
      RESOLVE: begin
        prod_d = sum_q + carry_q;
        state_d = DONE;
      end
`endif
      DONE: state_d = prod_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      k_q <= '0;
      prod_q <= '0;
`ifdef BOOTH_CSA_ACC_EN
      sum_q <= '0;
      carry_q <= '0;
`else
      acc_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      prod_q <= prod_d;
`ifdef BOOTH_CSA_ACC_EN
      sum_q <= sum_d;
      carry_q <= carry_d;
`else
      acc_q <= acc_d;
`endif
    end
  end
endmodule
